// File: rtl/bf16_div.sv
// bf16_div: bfloat16 divider (1/8/7, bias 127), sequential restoring division.
// Operands are latched on accept; special operands finish one edge later,
// normal operands take 9 DIV iterations plus one ROUND step.
// Subnormals are flushed to zero on input and output.
// Optional macro BF16_DIV_RNE_EN: round to nearest-even instead of truncating.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable while valid is high and ready low.
module bf16_div (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] result_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state;
  logic [15:0]        a_q, b_q;
  logic [9:0]         rem;
  logic [8:0]         quo;
  logic [3:0]         cnt;
  logic signed [9:0]  exp_q;

  // accept-time precompute: significands, pre-shift decision, biased exponent
  logic [7:0]  sa_in, sb_in;
  logic        lt_in;
  logic [9:0]  exp_in;
  always_comb begin
    sa_in  = {1'b1, a_i[6:0]};
    sb_in  = {1'b1, b_i[6:0]};
    lt_in  = sa_in < sb_in;
    exp_in = {2'b00, a_i[14:7]} - {2'b00, b_i[14:7]} + 10'd127 - {9'd0, lt_in};
  end

  // special-case classification of the latched operands
  logic        sc, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        spec_hit, spec_dz;
  logic [15:0] spec_res;
  always_comb begin
    sc       = a_q[15] ^ b_q[15];
    a_nan    = (a_q[14:7] == 8'hFF) && (a_q[6:0] != 7'd0);
    b_nan    = (b_q[14:7] == 8'hFF) && (b_q[6:0] != 7'd0);
    a_inf    = (a_q[14:7] == 8'hFF) && (a_q[6:0] == 7'd0);
    b_inf    = (b_q[14:7] == 8'hFF) && (b_q[6:0] == 7'd0);
    a_zero   = a_q[14:7] == 8'h00;
    b_zero   = b_q[14:7] == 8'h00;
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_res = 16'h0000;
    if (a_nan || b_nan)                          spec_res = 16'h7FC0;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) spec_res = 16'h7FC0;
    else if (b_zero && !a_inf) begin
      spec_res = {sc, 15'h7F80};
      spec_dz  = 1'b1;
    end
    else if (a_inf)                              spec_res = {sc, 15'h7F80};
    else if (a_zero || b_inf)                    spec_res = {sc, 15'h0000};
    else                                         spec_hit = 1'b0;
  end

  // one restoring-division step: subtract divisor when it fits, shift left
  logic [9:0] sb_ext, rem_sub, rem_next;
  logic       rem_ge;
  always_comb begin
    sb_ext   = {2'b00, 1'b1, b_q[6:0]};
    rem_ge   = rem >= sb_ext;
    rem_sub  = rem_ge ? (rem - sb_ext) : rem;
    rem_next = rem_sub << 1;
  end

  // rounding, renormalisation on carry, overflow/underflow clamp
  logic              guard, sticky, lsb, inc;
  logic [8:0]        mant_r;
  logic [6:0]        frac_f;
  logic signed [9:0] exp_fin;
  logic [15:0]       round_res;
  always_comb begin
    guard  = quo[0];
    lsb    = quo[1];
    sticky = rem != 10'd0;
`ifdef BF16_DIV_RNE_EN
    inc    = guard & (sticky | lsb);
`else
    // truncation: the rounding bits are computed but intentionally discarded
    inc    = 1'b0 & guard & (sticky | lsb);
`endif
    mant_r  = {1'b0, quo[8:1]} + {8'd0, inc};
    frac_f  = mant_r[8] ? mant_r[7:1] : mant_r[6:0];
    exp_fin = exp_q + (mant_r[8] ? 10'sd1 : 10'sd0);
    if (exp_fin >= 10'sd255)    round_res = {sc, 15'h7F80};
    else if (exp_fin <= 10'sd0) round_res = {sc, 15'h0000};
    else                        round_res = {sc, exp_fin[7:0], frac_f};
  end

  // control FSM with datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      rem        <= 10'd0;
      quo        <= 9'd0;
      cnt        <= 4'd0;
      exp_q      <= 10'sd0;
      result_o   <= 16'h0000;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          rem   <= lt_in ? {1'b0, sa_in, 1'b0} : {2'b00, sa_in};
          quo   <= 9'd0;
          cnt   <= 4'd0;
          exp_q <= $signed(exp_in);
          state <= DIV;
        end
        DIV: if (spec_hit) begin
          result_o   <= spec_res;
          div_zero_o <= spec_dz;
          state      <= DONE;
        end else begin
          quo <= {quo[7:0], rem_ge};
          rem <= rem_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) state <= ROUND;
        end
        ROUND: begin
          result_o   <= round_res;
          div_zero_o <= 1'b0;
          state      <= DONE;
        end
        DONE: if (out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = state == IDLE;
  assign out_valid_o = state == DONE;

endmodule
